// File: rtl/alu_bist_pkg.sv
// Shared types, ALU control encodings and the golden vector table for the ALU self-test.
package alu_bist_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CTRL_W  = 4;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FAIL_W  = 8;
    localparam int unsigned TBL_LEN = 24;

    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1001;

    // Marker meaning "no failing vector recorded yet".
    localparam logic [IDX_W-1:0] IDX_NONE = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_COMPARE,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   exp;
    } vec_t;

    // Only entry 15 yields zero, so a stuck Zero flag shows up at a single index.
    localparam vec_t VEC_TABLE [TBL_LEN] = '{
        '{ALU_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008},
        '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001},
        '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
        '{ALU_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE},
        '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF},
        '{ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
        '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
        '{ALU_XOR,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
        '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
        '{ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001},
        '{ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001},
        '{ALU_SLTU, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001},
        '{ALU_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
        '{ALU_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001},
        '{ALU_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF},
        '{ALU_ADD,  32'h0000_000A, 32'hFFFF_FFF6, 32'h0000_0000},
        '{ALU_SLL,  32'h0000_00FF, 32'hFFFF_FFE4, 32'h0000_0FF0},
        '{ALU_SRA,  32'h7FFF_FFF0, 32'h0000_0004, 32'h07FF_FFFF},
        '{ALU_SRL,  32'hF000_0000, 32'h0000_001C, 32'h0000_000F},
        '{ALU_XOR,  32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977},
        '{ALU_AND,  32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0001},
        '{ALU_OR,   32'h0000_0001, 32'h8000_0000, 32'h8000_0001},
        '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
        '{ALU_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001}
    };

endpackage

// File: rtl/alu_bist_rom.sv
// Combinational vector lookup; indices past the table return an all-zero ADD vector.
module alu_bist_rom
    import alu_bist_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output vec_t             vec_c
);

    always_comb begin
        vec_c = '0;
        if (32'(idx) < TBL_LEN) begin
            vec_c = VEC_TABLE[idx];
        end
    end

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test sequencer: steps the vector table through the ALU and tallies mismatches.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int unsigned NUM_VEC = 24,
    parameter int unsigned SETTLE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [FAIL_W-1:0] fail_count,
    output logic [IDX_W-1:0]  first_fail_idx,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [XLEN-1:0]   alu_result,
    input  logic              alu_zero
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [FAIL_W-1:0]   fail_d;
    logic [IDX_W-1:0]    first_fail_d;
    logic [XLEN-1:0]     a_d, b_d;
    logic [CTRL_W-1:0]   ctrl_d;
    logic                busy_d, done_d;
    vec_t                rom_vec_c;
    logic                mismatch_c;

    alu_bist_rom u_rom (
        .idx   (idx),
        .vec_c (rom_vec_c)
    );

    // Both Result and Zero must agree with the golden value.
    assign mismatch_c = (alu_result != rom_vec_c.exp) ||
                        (alu_zero != (rom_vec_c.exp == '0));

    assign pass = done && (fail_count == '0);

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cnt_d        = cnt;
        fail_d       = fail_count;
        first_fail_d = first_fail_idx;
        a_d          = alu_a;
        b_d          = alu_b;
        ctrl_d       = alu_ctrl;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fail_d       = '0;
                    first_fail_d = IDX_NONE;
                    idx_d        = '0;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                a_d     = rom_vec_c.a;
                b_d     = rom_vec_c.b;
                ctrl_d  = rom_vec_c.ctrl;
                cnt_d   = SETTLE_CNT;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (mismatch_c) begin
                    if (fail_count != '1) begin
                        fail_d = fail_count + FAIL_W'(1);
                    end
                    if (first_fail_idx == IDX_NONE) begin
                        first_fail_d = idx;
                    end
                end
                if (idx == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = ST_APPLY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags follow the next state so they change on the transition edge.
        busy_d = (state_d == ST_APPLY) || (state_d == ST_WAIT) || (state_d == ST_COMPARE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= '0;
            cnt            <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= IDX_NONE;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ctrl       <= '0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
            busy           <= busy_d;
            done           <= done_d;
            fail_count     <= fail_d;
            first_fail_idx <= first_fail_d;
            alu_a          <= a_d;
            alu_b          <= b_d;
            alu_ctrl       <= ctrl_d;
        end
    end

endmodule
